// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial sequence-scan controller.
package seq_scan_pkg;

   localparam int unsigned DefWordW = 8;
   localparam int unsigned DefPatMax = 4;
   localparam int unsigned DefCntW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StWaitWord,
      StShift,
      StDone
   } scan_state_e;

   // Width needed to hold a pattern length of 0..pat_max.
   function automatic int unsigned len_width(input int unsigned pat_max);
      return $clog2(pat_max + 1);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial Mealy pattern matcher: history register, fill counter, combinational compare.
// PAT_MAX must be at least 2.
module seq_match_core
   import seq_scan_pkg::*;
#(
   parameter int unsigned PAT_MAX = DefPatMax
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_bit,
   input  logic                          bit_en,
   input  logic                          clear,
   input  logic [PAT_MAX-1:0]            cfg_pat,
   input  logic [len_width(PAT_MAX)-1:0] cfg_len,
   output logic                          match
);

   localparam int unsigned LEN_W = len_width(PAT_MAX);

   logic [PAT_MAX-2:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [PAT_MAX-1:0] window;
   logic [PAT_MAX-1:0] mask;
   logic               fill_ok;

   // Bit 0 of the window is the newest bit; it lines up with cfg_pat[0].
   always_comb begin
      window = {hist_q, in_bit};
      mask = '0;
      for (int i = 0; i < PAT_MAX; i++) begin
         mask[i] = (LEN_W'(i) < cfg_len);
      end
      fill_ok = (fill_q >= (cfg_len - 1'b1));
      match = bit_en && fill_ok && (((window ^ cfg_pat) & mask) == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (clear) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (bit_en) begin
         hist_q <= window[PAT_MAX-2:0];
         if (fill_q < LEN_W'(PAT_MAX - 1)) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts words over valid/ready, serializes them MSB-first into the
// matcher, counts hits per frame and reports the final count at end of frame.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int unsigned WORD_W  = DefWordW,
   parameter int unsigned PAT_MAX = DefPatMax,
   parameter int unsigned CNT_W   = DefCntW
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   input  logic [PAT_MAX-1:0]            cfg_pat,
   input  logic [len_width(PAT_MAX)-1:0] cfg_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WORD_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          ser_bit,
   output logic                          hit,
   output logic [CNT_W-1:0]              hit_count,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int unsigned LEN_W = len_width(PAT_MAX);
   localparam int unsigned IDX_W = $clog2(WORD_W);

   scan_state_e        state_q;
   logic [WORD_W-1:0]  sreg_q;
   logic [IDX_W-1:0]   idx_q;
   logic               last_q;
   logic [PAT_MAX-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;

   logic cfg_ok;
   logic frame_start;
   logic bit_en;
   logic match;

   always_comb begin
      cfg_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
      frame_start = (state_q == StIdle) && start && cfg_ok && !abort;
      // A bit cut short by abort is not scored.
      bit_en      = (state_q == StShift) && !abort;
   end

   assign ser_bit = sreg_q[WORD_W-1];

   seq_match_core #(
      .PAT_MAX (PAT_MAX)
   ) u_match (
      .clk     (clk),
      .reset   (reset),
      .in_bit  (ser_bit),
      .bit_en  (bit_en),
      .clear   (frame_start),
      .cfg_pat (pat_q),
      .cfg_len (len_q),
      .match   (match)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         sreg_q    <= '0;
         idx_q     <= '0;
         last_q    <= 1'b0;
         pat_q     <= '0;
         len_q     <= '0;
         in_ready  <= 1'b0;
         hit       <= 1'b0;
         hit_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         hit  <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
         if (abort) begin
            state_q  <= StIdle;
            in_ready <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     if (!cfg_ok) begin
                        err <= 1'b1;
                     end else begin
                        pat_q     <= cfg_pat;
                        len_q     <= cfg_len;
                        hit_count <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= StWaitWord;
                     end
                  end
               end
               StWaitWord: begin
                  if (in_valid) begin
                     sreg_q   <= in_data;
                     last_q   <= in_last;
                     idx_q    <= IDX_W'(WORD_W - 1);
                     in_ready <= 1'b0;
                     state_q  <= StShift;
                  end
               end
               StShift: begin
                  sreg_q <= {sreg_q[WORD_W-2:0], 1'b0};
                  if (match) begin
                     hit <= 1'b1;
                     if (hit_count != {CNT_W{1'b1}}) begin
                        hit_count <= hit_count + 1'b1;
                     end
                  end
                  if (idx_q == '0) begin
                     if (last_q) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        in_ready <= 1'b1;
                        state_q  <= StWaitWord;
                     end
                  end else begin
                     idx_q <= idx_q - 1'b1;
                  end
               end
               StDone: begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
               default: begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  state_q  <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized self-checking bench for seq_scan_ctrl against a bit-list reference model.
module tb_seq_scan_ctrl;

   localparam int WW  = 8;
   localparam int PM  = 4;
   localparam int CW  = 8;
   localparam int CWS = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [PM-1:0] cfg_pat;
   logic [2:0]    cfg_len;
   logic          in_valid;
   logic [WW-1:0] in_data;
   logic          in_last;

   logic           in_ready, ser_bit, hit, busy, done, err;
   logic [CW-1:0]  hit_count;
   logic           in_ready_s, ser_bit_s, hit_s, busy_s, done_s, err_s;
   logic [CWS-1:0] hit_count_s;

   seq_scan_ctrl #(
      .WORD_W  (WW),
      .PAT_MAX (PM),
      .CNT_W   (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .cfg_pat   (cfg_pat),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .ser_bit   (ser_bit),
      .hit       (hit),
      .hit_count (hit_count),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   seq_scan_ctrl #(
      .WORD_W  (WW),
      .PAT_MAX (PM),
      .CNT_W   (CWS)
   ) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .cfg_pat   (cfg_pat),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready_s),
      .in_data   (in_data),
      .in_last   (in_last),
      .ser_bit   (ser_bit_s),
      .hit       (hit_s),
      .hit_count (hit_count_s),
      .busy      (busy_s),
      .done      (done_s),
      .err       (err_s)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   bit hist[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   // Match if the newest len bits of the frame equal pat[len-1:0], pat[0] newest.
   function automatic bit model_match(input logic [PM-1:0] pat, input int len);
      if (hist.size() < len) return 1'b0;
      for (int i = 0; i < len; i++) begin
         if (hist[hist.size() - 1 - i] != pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_cnt"}, 32'(hit_count), 32'(sat(exp_cnt, CW)));
      check({tag, "_cnt_sat"}, 32'(hit_count_s), 32'(sat(exp_cnt, CWS)));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'({in_ready, in_ready_s}), 32'd0);
      check({tag, "_ser"}, 32'({ser_bit, ser_bit_s}), 32'd0);
      check({tag, "_hit"}, 32'({hit, hit_s}), 32'd0);
      check({tag, "_busy"}, 32'({busy, busy_s}), 32'd0);
      check({tag, "_done"}, 32'({done, done_s}), 32'd0);
      check({tag, "_err"}, 32'({err, err_s}), 32'd0);
      check({tag, "_count"}, 32'({hit_count, hit_count_s}), 32'd0);
   endtask

   task automatic do_start(input logic [PM-1:0] pat, input int len);
      start = 1'b1;
      cfg_pat = pat;
      cfg_len = 3'(len);
      step();
      start = 1'b0;
      hist.delete();
      exp_cnt = 0;
      check("start_ready", 32'(in_ready), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check_counts("start");
   endtask

   // Entered in a WAIT_WORD cycle; leaves in WAIT_WORD (not last) or IDLE (last).
   task automatic shift_word(input logic [WW-1:0] w, input bit last, input bit noise,
                             input logic [PM-1:0] pat, input int len);
      bit m;
      repeat ($urandom_range(0, 2)) begin
         in_valid = 1'b0;
         step();
         check("wait_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_data = w;
      in_last = last;
      step();
      check("accept_hit", 32'(hit), 32'd0);
      for (int b = WW - 1; b >= 0; b--) begin
         check("ser_bit", 32'(ser_bit), 32'(w[b]));
         check("shift_ready", 32'(in_ready), 32'd0);
         check("shift_done", 32'(done), 32'd0);
         check("shift_busy", 32'(busy), 32'd1);
         hist.push_back(w[b]);
         m = model_match(pat, len);
         if (m) exp_cnt++;
         if (noise) begin
            in_valid = 1'($urandom);
            in_data = WW'($urandom);
            start = ($urandom_range(0, 3) == 0);
            cfg_pat = PM'($urandom);
            cfg_len = 3'($urandom);
         end
         step();
         check("hit", 32'(hit), 32'(m));
         check("hit_sat", 32'(hit_s), 32'(m));
         check_counts("shift");
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      start = 1'b0;
      if (last) begin
         check("done_pulse", 32'(done), 32'd1);
         check("done_busy", 32'(busy), 32'd1);
         check("done_ready", 32'(in_ready), 32'd0);
         step();
         check("post_done", 32'(done), 32'd0);
         check("post_busy", 32'(busy), 32'd0);
         check("post_ready", 32'(in_ready), 32'd0);
         check_counts("post");
      end else begin
         check("next_ready", 32'(in_ready), 32'd1);
         check("next_done", 32'(done), 32'd0);
      end
   endtask

   initial begin
      bit m;
      logic [PM-1:0] pat;
      int len;
      int nw;
      bit noise;

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cfg_pat = '0;
      cfg_len = '0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      step();
      step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Single word, overlapping pattern 101.
      do_start(4'b0101, 3);
      shift_word(8'b10101101, 1'b1, 1'b0, 4'b0101, 3);
      check("t1_total", 32'(hit_count), 32'd3);

      // Match spanning the word boundary.
      do_start(4'b0101, 3);
      shift_word(8'b00000010, 1'b0, 1'b0, 4'b0101, 3);
      shift_word(8'b10000000, 1'b1, 1'b0, 4'b0101, 3);
      check("t2_total", 32'(hit_count), 32'd1);

      // Saturation on the narrow-counter instance.
      do_start(4'b0001, 1);
      shift_word(8'hFF, 1'b1, 1'b0, 4'b0001, 1);
      check("t3_total", 32'(hit_count), 32'd8);
      check("t3_total_sat", 32'(hit_count_s), 32'd3);

      // Illegal lengths.
      for (int k = 0; k < 3; k++) begin
         start = 1'b1;
         cfg_len = (k == 0) ? 3'd0 : 3'(4 + k);
         step();
         start = 1'b0;
         check("err_pulse", 32'(err), 32'd1);
         check("err_ready", 32'(in_ready), 32'd0);
         check("err_busy", 32'(busy), 32'd0);
         check_counts("err");
         step();
         check("err_clear", 32'(err), 32'd0);
         check("err_idle", 32'(in_ready), 32'd0);
      end

      // Abort on the fourth shift cycle, with start and valid in the same cycle.
      do_start(4'b0011, 2);
      in_valid = 1'b1;
      in_data = 8'hFF;
      in_last = 1'b1;
      step();
      in_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         hist.push_back(1'b1);
         m = model_match(4'b0011, 2);
         if (m) exp_cnt++;
         step();
         check("ab_hit", 32'(hit), 32'(m));
      end
      abort = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("ab_ready", 32'(in_ready), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_done", 32'(done), 32'd0);
      check("ab_hit_off", 32'(hit), 32'd0);
      check("ab_total", 32'(hit_count), 32'd2);
      repeat (3) begin
         step();
         check("ab_no_done", 32'(done), 32'd0);
         check("ab_held_valid", 32'(in_ready), 32'd0);
         check("ab_idle_busy", 32'(busy), 32'd0);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      do_start(4'b0011, 2);
      shift_word(8'h0F, 1'b1, 1'b0, 4'b0011, 2);

      // Asynchronous reset mid-shift; no matches against stale history afterwards.
      do_start(4'b0011, 2);
      in_valid = 1'b1;
      in_data = 8'hFF;
      in_last = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      in_last = 1'b0;
      exp_cnt = 0;
      hist.delete();
      step();
      check("rst_idle_ready", 32'(in_ready), 32'd0);
      do_start(4'b0011, 2);
      shift_word(8'b10000000, 1'b1, 1'b0, 4'b0011, 2);
      check("rst_no_stale", 32'(hit_count), 32'd0);

      // Randomized frames, with ignored starts and held valids during shifting.
      for (int f = 0; f < 40; f++) begin
         pat = PM'($urandom);
         len = $urandom_range(1, PM);
         nw = $urandom_range(1, 3);
         noise = 1'($urandom);
         do_start(pat, len);
         for (int w = 0; w < nw; w++) begin
            shift_word(WW'($urandom), (w == nw - 1), noise, pat, len);
         end
         repeat ($urandom_range(0, 3)) begin
            step();
            check("idle_ready", 32'(in_ready), 32'd0);
            check_counts("idle_hold");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
